// File: rtl/vga_timing_gen_if.sv
// Raster timing bus between the timing generator (master) and the renderer (slave).
// frame_cnt is only present when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic             pix_en;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             blank;
  logic             Hsync;
  logic             Vsync;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]      frame_cnt;

  modport master (
    input  pix_en,
    output hcount, vcount, blank, Hsync, Vsync, line_start, frame_start, frame_cnt
  );
  modport slave (
    output pix_en,
    input  hcount, vcount, blank, Hsync, Vsync, line_start, frame_start, frame_cnt
  );
`else
  modport master (
    input  pix_en,
    output hcount, vcount, blank, Hsync, Vsync, line_start, frame_start
  );
  modport slave (
    output pix_en,
    input  hcount, vcount, blank, Hsync, Vsync, line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel coordinates, blanking and H/V sync from one
// pixel clock. All outputs are registered from combinational next-state values so
// blank/sync always describe the coordinates presented in the same cycle.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 11
) (
  input logic             clk,
  input logic             resetn,
  vga_timing_gen_if.master vga
);

  localparam logic [CNT_W-1:0] hTotal  = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] vTotM1  = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] hActive = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] vActive = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] hsStart = CNT_W'(H_ACTIVE + H_FP + 1);
  localparam logic [CNT_W-1:0] hsEnd   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] vsStart = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] vsEnd   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] one     = CNT_W'(1);

  logic [CNT_W-1:0] hNext, vNext;
  logic             blankNext, hsNext, vsNext;
  logic             wrapLine, wrapFrame;

  // Next raster position and the flags that belong to it; holds when pix_en is low.
  always_comb begin
    hNext     = vga.hcount;
    vNext     = vga.vcount;
    wrapLine  = 1'b0;
    wrapFrame = 1'b0;
    if (vga.pix_en) begin
      if (vga.hcount == hTotal) begin
        hNext     = one;
        wrapLine  = 1'b1;
        wrapFrame = (vga.vcount == vTotM1);
        vNext     = wrapFrame ? '0 : vga.vcount + one;
      end else begin
        hNext = vga.hcount + one;
      end
    end
    // hcount is 1-based, so 0 is never visible; vsync edges land on hcount=1
    // because vNext only changes on the line wrap.
    blankNext = !((hNext != '0) && (hNext <= hActive) && (vNext < vActive));
    hsNext    = ((hNext >= hsStart) && (hNext <= hsEnd)) ? SYNC_POL : ~SYNC_POL;
    vsNext    = ((vNext >= vsStart) && (vNext <= vsEnd)) ? SYNC_POL : ~SYNC_POL;
  end

  // Output registers; reset parks the raster on the last pixel of the frame so the
  // first enabled step lands on (1,0) with both start pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga.hcount      <= hTotal;
      vga.vcount      <= vTotM1;
      vga.blank       <= 1'b1;
      vga.Hsync       <= ~SYNC_POL;
      vga.Vsync       <= ~SYNC_POL;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.hcount      <= hNext;
      vga.vcount      <= vNext;
      vga.blank       <= blankNext;
      vga.Hsync       <= hsNext;
      vga.Vsync       <= vsNext;
      vga.line_start  <= wrapLine;
      vga.frame_start <= wrapFrame;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter steps in the same cycle frame_start is presented, wrapping naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        vga.frame_cnt <= 16'h0000;
    else if (wrapFrame) vga.frame_cnt <= vga.frame_cnt + 16'h0001;
  end
`endif

endmodule
